// File: rtl/game_ms_timer_if.sv
// Purpose : bus between the debounced buttons, the ms timer and the countdown/display logic.
// Latency : wiring only; the timer registers every output it drives onto this bus.
// Backpres: none; START/STOP are single-cycle pulses and the outputs are plain levels or pulses.
//
// Signals:
//   START, STOP   - button pulses from the debouncer (driven by the master side)
//   COUNT1        - elapsed milliseconds since START (feeds the countdown decoder)
//   RUNNING       - round is timing
//   DONE          - one-cycle pulse when COUNT1 reaches the target instant
//   RESULT        - COUNT1 captured at stop or timeout
//   RESULT_VALID  - RESULT/EARLY/SCORE/TIMEOUT are meaningful
//   TIMEOUT       - round ended by the ceiling rather than by STOP
//   EARLY         - RESULT below the target
//   SCORE         - absolute distance between RESULT and the target
interface game_ms_timer_if;
    logic        START;
    logic        STOP;
    logic [31:0] COUNT1;
    logic        RUNNING;
    logic        DONE;
    logic [31:0] RESULT;
    logic        RESULT_VALID;
    logic        TIMEOUT;
    logic        EARLY;
    logic [31:0] SCORE;

    // Button/consumer side: produces the pulses, observes the timer.
    modport master (
        output START, STOP,
        input  COUNT1, RUNNING, DONE, RESULT, RESULT_VALID, TIMEOUT, EARLY, SCORE
    );

    // Timer side.
    modport slave (
        input  START, STOP,
        output COUNT1, RUNNING, DONE, RESULT, RESULT_VALID, TIMEOUT, EARLY, SCORE
    );
endinterface

// File: rtl/game_ms_timer.sv
// Purpose : millisecond timebase for the countdown game; runs a round from START, captures STOP/timeout.
// Latency : START/STOP take effect on the sampling edge (1 cycle to outputs); COUNT1 steps every TICK_DIV cycles.
// Backpres: none; pulses arriving in states that ignore them are dropped.
//
// Ports:
//   CLK   - system clock, everything on the rising edge
//   RESET - synchronous active-high reset, overrides all other inputs
//   io    - game_ms_timer_if.slave: START/STOP in, COUNT1/RUNNING/DONE/RESULT/RESULT_VALID/
//           TIMEOUT/EARLY/SCORE out (all registered)
module game_ms_timer #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned GAME_MS  = 5000,
    parameter int unsigned MAX_MS   = 9999
) (
    input  logic            CLK,
    input  logic            RESET,
    game_ms_timer_if.slave  io
);

    localparam int unsigned   PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [31:0]   GAME_V     = 32'(GAME_MS);
    localparam logic [31:0]   MAX_V      = 32'(MAX_MS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic [31:0]   result_q, result_d;
    logic          result_vld_q, result_vld_d;
    logic          timeout_q, timeout_d;
    logic          early_q, early_d;
    logic [31:0]   score_q, score_d;

    // Shared round-progress terms.
    logic        tick;
    logic [31:0] count_inc;
    logic        hit_max;

    assign tick      = (presc_q == PRESC_LAST);
    assign count_inc = count_q + 32'd1;
    assign hit_max   = tick && (count_inc == MAX_V);

    // Value captured when a round ends. STOP beats a coincident tick, so STOP
    // always captures the pre-increment count; otherwise the end is the timeout.
    logic [31:0] end_val;
    logic        end_early;
    logic [31:0] end_score;

    always_comb begin
        end_val   = io.STOP ? count_q : MAX_V;
        end_early = (end_val < GAME_V);
        end_score = end_early ? (GAME_V - end_val) : (end_val - GAME_V);
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (io.START) state_d = ST_RUN;
            end
            ST_RUN: begin
                // START is ignored while running; STOP (even alongside START) ends the round.
                if (io.STOP || hit_max) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (io.START) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        presc_d      = presc_q;
        count_d      = count_q;
        done_d       = 1'b0;
        result_d     = result_q;
        result_vld_d = result_vld_q;
        timeout_d    = timeout_q;
        early_d      = early_q;
        score_d      = score_q;
        running_d    = (state_d == ST_RUN);

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                // HOLD keeps COUNT1 frozen so the decoder keeps showing the final digit.
                if (io.START) begin
                    presc_d      = '0;
                    count_d      = '0;
                    result_vld_d = 1'b0;
                    timeout_d    = 1'b0;
                    early_d      = 1'b0;
                    score_d      = '0;
                end
            end
            ST_RUN: begin
                if (io.STOP) begin
                    result_d     = end_val;
                    result_vld_d = 1'b1;
                    early_d      = end_early;
                    score_d      = end_score;
                end else if (tick) begin
                    presc_d = '0;
                    count_d = count_inc;
                    done_d  = (count_inc == GAME_V);
                    if (hit_max) begin
                        result_d     = end_val;
                        result_vld_d = 1'b1;
                        timeout_d    = 1'b1;
                        early_d      = end_early;
                        score_d      = end_score;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                count_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q      <= '0;
            count_q      <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
            timeout_q    <= 1'b0;
            early_q      <= 1'b0;
            score_q      <= '0;
        end else begin
            presc_q      <= presc_d;
            count_q      <= count_d;
            running_q    <= running_d;
            done_q       <= done_d;
            result_q     <= result_d;
            result_vld_q <= result_vld_d;
            timeout_q    <= timeout_d;
            early_q      <= early_d;
            score_q      <= score_d;
        end
    end

    assign io.COUNT1       = count_q;
    assign io.RUNNING      = running_q;
    assign io.DONE         = done_q;
    assign io.RESULT       = result_q;
    assign io.RESULT_VALID = result_vld_q;
    assign io.TIMEOUT      = timeout_q;
    assign io.EARLY        = early_q;
    assign io.SCORE        = score_q;

endmodule

// File: tb/tb_game_ms_timer.sv
// Purpose : self-checking bench for game_ms_timer (TICK_DIV=4, GAME_MS=10, MAX_MS=20).
// Latency : outputs sampled 1 time unit after each rising edge, against an elapsed-cycle model.
// Backpres: n/a.
module tb_game_ms_timer;
    localparam int T = 4;
    localparam int G = 10;
    localparam int M = 20;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    game_ms_timer_if bus();

    game_ms_timer #(.TICK_DIV(T), .GAME_MS(G), .MAX_MS(M)) dut (
        .CLK   (clk),
        .RESET (rst),
        .io    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a round is described by the number of edges elapsed since
    // START; the count is simply elapsed / TICK_DIV.
    bit m_run, m_done, m_vld, m_to, m_early;
    int m_e, m_count, m_result, m_score;

    int done_cnt;
    int done_pos;

    typedef struct {
        int stop_edge;   // edge after START at which STOP is sampled (0 = never)
        int run_cycles;
        int exp_result;
        bit exp_to;
        bit exp_early;
        int exp_score;
        int exp_done;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit s, input bit p, input bit r);
        m_done = 1'b0;
        if (r) begin
            m_run = 0; m_e = 0; m_count = 0; m_result = 0;
            m_vld = 0; m_to = 0; m_early = 0; m_score = 0;
        end else if (m_run) begin
            if (p) begin
                m_run    = 0;
                m_result = m_e / T;
                m_vld    = 1;
            end else begin
                m_e++;
                m_count = m_e / T;
                m_done  = (m_e == G * T);
                if (m_e == M * T) begin
                    m_run = 0; m_result = M; m_vld = 1; m_to = 1;
                end
            end
            if (!m_run) begin
                m_early = (m_result < G);
                m_score = m_early ? (G - m_result) : (m_result - G);
            end
        end else if (s) begin
            m_run = 1; m_e = 0; m_count = 0;
            m_vld = 0; m_to = 0; m_early = 0; m_score = 0;
        end
    endtask

    task automatic cmp_model();
        chk("count1",       bus.COUNT1,       m_count);
        chk("running",      bus.RUNNING,      m_run);
        chk("done",         bus.DONE,         m_done);
        chk("result_valid", bus.RESULT_VALID, m_vld);
        chk("timeout",      bus.TIMEOUT,      m_to);
        chk("early",        bus.EARLY,        m_early);
        chk("score",        bus.SCORE,        m_score);
        chk("result",       bus.RESULT,       m_result);
    endtask

    task automatic step(input bit s, input bit p, input bit r);
        bus.START = s;
        bus.STOP  = p;
        rst       = r;
        @(posedge clk);
        model_edge(s, p, r);
        #1;
        if (bus.DONE === 1'b1) begin
            done_cnt++;
            done_pos = m_e;
        end
        cmp_model();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count1"},  bus.COUNT1,       32'd0);
        chk({tag, "_running"}, bus.RUNNING,      32'd0);
        chk({tag, "_done"},    bus.DONE,         32'd0);
        chk({tag, "_result"},  bus.RESULT,       32'd0);
        chk({tag, "_rvalid"},  bus.RESULT_VALID, 32'd0);
        chk({tag, "_timeout"}, bus.TIMEOUT,      32'd0);
        chk({tag, "_early"},   bus.EARLY,        32'd0);
        chk({tag, "_score"},   bus.SCORE,        32'd0);
    endtask

    initial begin
        tbl[0] = '{53, 85, 13, 1'b0, 1'b0,  3, 1};  // late stop
        tbl[1] = '{32, 85,  7, 1'b0, 1'b1,  3, 0};  // stop on 7->8 tick edge
        tbl[2] = '{ 0, 85, 20, 1'b1, 1'b0, 10, 1};  // timeout
        tbl[3] = '{83, 85, 20, 1'b1, 1'b0, 10, 1};  // STOP after timeout is ignored
        tbl[4] = '{41, 85, 10, 1'b0, 1'b0,  0, 1};  // exact hit
        tbl[5] = '{ 1, 85,  0, 1'b0, 1'b1, 10, 0};  // immediate stop
        tbl[6] = '{80, 85, 19, 1'b0, 1'b0,  9, 1};  // STOP beats the MAX tick
        tbl[7] = '{40, 85,  9, 1'b0, 1'b1,  1, 0};  // STOP beats the GAME tick, no DONE
        tbl[8] = '{79, 85, 19, 1'b0, 1'b0,  9, 1};

        done_cnt = 0;
        done_pos = 0;
        m_run = 0; m_e = 0; m_count = 0; m_result = 0;
        m_vld = 0; m_to = 0; m_early = 0; m_score = 0; m_done = 0;

        // 1. reset, then STOP in IDLE is ignored
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        chk_all_zero("reset");
        step(0, 1, 0);
        step(0, 0, 0);
        chk_all_zero("idle_stop");

        // 2-4. table of complete rounds
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 0);
            chk("tbl_start_running", bus.RUNNING, 32'd1);
            chk("tbl_start_count",   bus.COUNT1,  32'd0);
            done_cnt = 0;
            for (int e = 1; e <= tbl[i].run_cycles; e++)
                step(0, (e == tbl[i].stop_edge), 0);
            chk("tbl_result",  bus.RESULT,       tbl[i].exp_result);
            chk("tbl_count1",  bus.COUNT1,       tbl[i].exp_result);
            chk("tbl_timeout", bus.TIMEOUT,      tbl[i].exp_to);
            chk("tbl_early",   bus.EARLY,        tbl[i].exp_early);
            chk("tbl_score",   bus.SCORE,        tbl[i].exp_score);
            chk("tbl_running", bus.RUNNING,      32'd0);
            chk("tbl_rvalid",  bus.RESULT_VALID, 32'd1);
            chk("tbl_done_cnt", done_cnt,        tbl[i].exp_done);
            if (tbl[i].exp_done == 1)
                chk("tbl_done_pos", done_pos, G * T);
        end

        // 5. START during RUN is ignored; START in HOLD restarts
        step(1, 0, 0);
        for (int e = 1; e <= 20; e++) step(0, 0, 0);
        chk("run_cnt5", bus.COUNT1, 32'd5);
        step(1, 0, 0);
        for (int e = 0; e < 3; e++) step(0, 0, 0);
        chk("run_cnt6",     bus.COUNT1,  32'd6);
        chk("run_still_on", bus.RUNNING, 32'd1);
        step(1, 1, 0);                       // START+STOP together acts as STOP
        chk("startstop_result",  bus.RESULT,  32'd6);
        chk("startstop_running", bus.RUNNING, 32'd0);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("hold_restart_cnt",    bus.COUNT1,       32'd0);
        chk("hold_restart_rvalid", bus.RESULT_VALID, 32'd0);
        chk("hold_restart_run",    bus.RUNNING,      32'd1);

        // 6. reset mid-round at COUNT1=9, no DONE afterwards
        for (int e = 1; e <= 36; e++) step(0, 0, 0);
        chk("pre_reset_cnt", bus.COUNT1, 32'd9);
        step(0, 0, 1);
        chk_all_zero("mid_reset");
        done_cnt = 0;
        for (int e = 0; e < 20; e++) step(0, 0, 0);
        chk("post_reset_done", done_cnt,   32'd0);
        chk("post_reset_cnt",  bus.COUNT1, 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit s, p, r;
            s = ($urandom_range(0, 99) < 3);
            p = ($urandom_range(0, 99) < 2);
            r = ($urandom_range(0, 999) < 2);
            step(s, p, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
